echo_capture_ctrl: RTL

- Sequences one sonar ping/echo frame and feeds the double-buffered sample RAMs that the display reads.
- Per frame it:
  - drives the transducer burst on the complementary ping pins;
  - skips the ring-down samples;
  - rectifies 2048 samples from all 8 ADC channels and writes them into the back bank;
  - swaps banks on the display's vertical sync.
- Sits between the 8 ADC readers (upstream) and the 8 simple-dual-port RAM write ports / LCD read-bank select (downstream).

---
 rtl/sonar_pkg.sv | 23 ++
 rtl/echo_rectify.sv | 49 ++++
 rtl/echo_capture_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/sonar_pkg.sv
// ---------------------------------------------------------------------------
// sonar_pkg : shared types and constants for the sonar echo capture path
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sonar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PING      = 3'd1,
    BLANK     = 3'd2,
    CAPTURE   = 3'd3,
    WAIT_SWAP = 3'd4
  } state_t;

  localparam int MIDSCALE = 128;
  localparam int NUM_CH   = 8;
  localparam int SAMPLE_W = 8;

endpackage

`default_nettype wire

// File: rtl/echo_rectify.sv
// ---------------------------------------------------------------------------
// echo_rectify : one channel, registered |s - MIDSCALE| saturated and doubled
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module echo_rectify
  import sonar_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [SAMPLE_W-1:0] rect_o
);

  localparam logic [SAMPLE_W-1:0] MID_C = SAMPLE_W'(MIDSCALE);
  localparam logic [SAMPLE_W-1:0] MAX_C = SAMPLE_W'(MIDSCALE - 1);

  logic [SAMPLE_W-1:0] diff_w;
  logic [SAMPLE_W-1:0] mag_w;
  logic [SAMPLE_W-1:0] rect_d;
  logic [SAMPLE_W-1:0] rect_q;

  // Only input 0 reaches 128, so saturating to 127 keeps the doubled value in range.
  always_comb begin
    diff_w = '0;
    if (sample_i >= MID_C) begin
      diff_w = sample_i - MID_C;
    end else begin
      diff_w = MID_C - sample_i;
    end
    mag_w  = (diff_w > MAX_C) ? MAX_C : diff_w;
    rect_d = {mag_w[SAMPLE_W-2:0], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rect_q <= '0;
    end else if (en_i) begin
      rect_q <= rect_d;
    end
  end

  assign rect_o = rect_q;

endmodule

`default_nettype wire

// File: rtl/echo_capture_ctrl.sv
// ---------------------------------------------------------------------------
// echo_capture_ctrl : ping burst, blanking, rectified capture, bank swap
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module echo_capture_ctrl
  import sonar_pkg::*;
#(
  parameter int SAMPLES       = 2048,
  parameter int ADDR_W        = 11,
  parameter int PING_HALF     = 675,
  parameter int PING_PULSES   = 8,
  parameter int BLANK_SAMPLES = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic                         sample_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0]   samples,
  input  logic                         frame_sync,
  output logic                         ping_p,
  output logic                         ping_n,
  output logic                         wr_en,
  output logic [ADDR_W:0]              wr_addr,
  output logic [NUM_CH*SAMPLE_W-1:0]   wr_data,
  output logic                         rd_bank,
  output logic                         busy
);

  localparam int CYC_W  = $clog2(PING_HALF + 1);
  localparam int HALF_W = $clog2(2 * PING_PULSES + 1);
  localparam int BLK_W  = $clog2(BLANK_SAMPLES + 1);

  localparam logic [CYC_W-1:0]  CYC_LAST_C  = CYC_W'(PING_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_LAST_C = HALF_W'(2 * PING_PULSES - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST_C  = BLK_W'(BLANK_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST_C  = ADDR_W'(SAMPLES - 1);

  state_t             state_q;
  logic [CYC_W-1:0]   cyc_q;
  logic [HALF_W-1:0]  half_q;
  logic [BLK_W-1:0]   blank_q;
  logic [ADDR_W-1:0]  idx_q;
  logic               wr_bank_q;
  logic               rd_bank_q;
  logic               fs_prev_q;
  logic               ping_p_q;
  logic               ping_n_q;
  logic               wr_en_q;
  logic [ADDR_W:0]    wr_addr_q;

  logic               cap_strobe_w;
  logic               fs_rise_w;

  assign cap_strobe_w = (state_q == CAPTURE) && sample_valid;
  assign fs_rise_w    = frame_sync && !fs_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_q     <= '0;
      half_q    <= '0;
      blank_q   <= '0;
      idx_q     <= '0;
      wr_bank_q <= 1'b1;
      rd_bank_q <= 1'b0;
      fs_prev_q <= 1'b0;
      ping_p_q  <= 1'b0;
      ping_n_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      fs_prev_q <= frame_sync;
      wr_en_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (run) begin
            state_q  <= PING;
            ping_p_q <= 1'b1;
            ping_n_q <= 1'b0;
            cyc_q    <= '0;
            half_q   <= '0;
          end
        end
        PING: begin
          if (cyc_q == CYC_LAST_C) begin
            cyc_q <= '0;
            if (half_q == HALF_LAST_C) begin
              state_q  <= BLANK;
              half_q   <= '0;
              ping_p_q <= 1'b0;
              ping_n_q <= 1'b0;
            end else begin
              half_q   <= half_q + HALF_W'(1);
              ping_p_q <= ~ping_p_q;
              ping_n_q <= ping_p_q;
            end
          end else begin
            cyc_q <= cyc_q + CYC_W'(1);
          end
        end
        BLANK: begin
          if (sample_valid) begin
            if (blank_q == BLK_LAST_C) begin
              blank_q <= '0;
              idx_q   <= '0;
              state_q <= CAPTURE;
            end else begin
              blank_q <= blank_q + BLK_W'(1);
            end
          end
        end
        CAPTURE: begin
          if (sample_valid) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {wr_bank_q, idx_q};
            if (idx_q == IDX_LAST_C) begin
              idx_q   <= '0;
              state_q <= WAIT_SWAP;
            end else begin
              idx_q <= idx_q + ADDR_W'(1);
            end
          end
        end
        WAIT_SWAP: begin
          // A level already high on entry is not an edge; the display must start a new frame.
          if (fs_rise_w) begin
            rd_bank_q <= wr_bank_q;
            wr_bank_q <= ~wr_bank_q;
            if (run) begin
              state_q  <= PING;
              ping_p_q <= 1'b1;
              ping_n_q <= 1'b0;
              cyc_q    <= '0;
              half_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_rect
    echo_rectify u_rect (
      .clk      (clk),
      .rst      (rst),
      .en_i     (cap_strobe_w),
      .sample_i (samples[k*SAMPLE_W +: SAMPLE_W]),
      .rect_o   (wr_data[k*SAMPLE_W +: SAMPLE_W])
    );
  end

  assign ping_p  = ping_p_q;
  assign ping_n  = ping_n_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign rd_bank = rd_bank_q;
  assign busy    = (state_q != IDLE);

endmodule

`default_nettype wire
